muldiv_sequencer: RTL and testbench

// Multi-cycle multiply/divide engine and sequencer beside the single-cycle ALU.

---
 rtl/muldiv_sequencer.sv | 121 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply / divide engine that stalls the pipeline while it runs
//   clk         in  system clock, rising edge
//   rst_n       in  asynchronous reset, active low
//   start       in  decode stage presents a valid ALU op
//   controle    in  ALU control word (CTRL_MULT / CTRL_DIV are executed, others ignored)
//   op_a, op_b  in  two's complement operands (multiplicand/dividend, multiplier/divisor)
//   abort       in  pipeline flush, cancels the operation in flight
//   stall       out combinational pipeline freeze
//   busy        out registered, iterating
//   done        out registered one-cycle result-valid pulse
//   result      out registered low product bits or quotient
//   div_by_zero out registered, set with done on divide by zero
module muldiv_sequencer #(
    parameter int         WIDTH     = 32,
    parameter logic [4:0] CTRL_MULT = 5'd2,
    parameter logic [4:0] CTRL_DIV  = 5'd3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       controle,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic             is_div;
    logic             sign;
    logic [CW-1:0]    cnt;
    // acc: product accumulator or partial remainder
    // x:   multiplier (shifts right) or dividend/quotient (shifts left)
    // y:   multiplicand (shifts left) or divisor
    logic [WIDTH-1:0] acc, x, y;
    logic             op_ok, accept, last;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   sh, diff;
    logic             no_borrow;
    logic [WIDTH-1:0] acc_nx, x_nx, y_nx, raw;

    assign op_ok  = start && (controle == CTRL_MULT || controle == CTRL_DIV);
    assign accept = op_ok && !abort && (state == IDLE || state == FIN);
    assign stall  = (state == RUN) || accept;
    assign last   = cnt == CW'(WIDTH - 1);
    assign abs_a  = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b  = op_b[WIDTH-1] ? -op_b : op_b;

    always_comb begin
        sh        = {acc, x[WIDTH-1]};
        diff      = sh - {1'b0, y};
        no_borrow = sh >= {1'b0, y};
        acc_nx    = is_div ? (no_borrow ? diff[WIDTH-1:0] : sh[WIDTH-1:0])
                           : (x[0] ? acc + y : acc);
        x_nx      = is_div ? {x[WIDTH-2:0], no_borrow} : x >> 1;
        y_nx      = is_div ? y : y << 1;
        raw       = is_div ? x_nx : acc_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_div      <= 1'b0;
            sign        <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            x           <= '0;
            y           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (accept) begin
            is_div      <= controle == CTRL_DIV;
            sign        <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            cnt         <= '0;
            acc         <= '0;
            x           <= (controle == CTRL_DIV) ? abs_a : abs_b;
            y           <= (controle == CTRL_DIV) ? abs_b : abs_a;
            div_by_zero <= 1'b0;
            if (controle == CTRL_DIV && op_b == '0) begin
                // no iterations needed: report all-ones quotient immediately
                state       <= FIN;
                busy        <= 1'b0;
                done        <= 1'b1;
                result      <= '1;
                div_by_zero <= 1'b1;
            end else begin
                state <= RUN;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end else if (state == RUN) begin
            acc <= acc_nx;
            x   <= x_nx;
            y   <= y_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                state  <= FIN;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= sign ? -raw : raw;
            end
        end else begin
            state <= IDLE;
            done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for the multiply/divide sequencer
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  controle = 5'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        abort = 1'b0;
    logic        stall, busy, done, div_by_zero;
    logic [31:0] result;
    int          checks = 0;
    int          errors = 0;

    localparam logic [4:0] MUL = 5'd2;
    localparam logic [4:0] DIV = 5'd3;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .controle(controle),
        .op_a(op_a), .op_b(op_b), .abort(abort), .stall(stall), .busy(busy),
        .done(done), .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and follow it to done. inj>0 presents a
    // competing divide start in that RUN cycle, which must be ignored.
    task automatic op(input string tag, input logic [4:0] ctl, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res,
                      input logic exp_dbz, input int exp_lat, input int inj);
        int n;
        int low;
        start = 1'b1; controle = ctl; op_a = a; op_b = b;
        #1;
        chk({tag, ".stall_acc"}, 32'(stall), 32'd1);
        tick();
        chk({tag, ".busy"}, 32'(busy), 32'(exp_lat > 1));
        n = 1;
        low = 0;
        while (!done && n < 100) begin
            start = (n == inj);
            controle = DIV; op_a = ~a; op_b = 32'd1;
            #1;
            if (!stall) low++;
            tick();
            n++;
        end
        start = 1'b0;
        #1;
        chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
        chk({tag, ".stall_run"}, 32'(low), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        chk({tag, ".stall_fin"}, 32'(stall), 32'd0);
    endtask

    initial begin
        int cnt;
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.dbz", 32'(div_by_zero), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        tick();

        op("mul7x6", MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33, 0);
        // back-to-back: each op below is issued in the previous op's done cycle
        op("div-20/3", DIV, -32'd20, 32'd3, 32'hFFFFFFFA, 1'b0, 33, 0);
        op("mul-5x4", MUL, -32'd5, 32'd4, 32'hFFFFFFEC, 1'b0, 33, 0);
        op("div9/0", DIV, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b1, 1, 0);
        op("div8/2", DIV, 32'd8, 32'd2, 32'd4, 1'b0, 33, 0);
        op("divmin/-1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33, 0);
        op("div100/-7", DIV, 32'd100, -32'd7, 32'hFFFFFFF2, 1'b0, 33, 0);
        op("mul-1x-1", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 33, 0);
        op("mulovf", MUL, 32'h00010000, 32'h00010003, 32'h00030000, 1'b0, 33, 0);
        op("mulminx-1", MUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33, 0);
        tick();

        start = 1'b1; controle = 5'd0; op_a = 32'd1; op_b = 32'd2;
        #1;
        chk("add.stall", 32'(stall), 32'd0);
        tick();
        start = 1'b0;
        chk("add.busy", 32'(busy), 32'd0);
        chk("add.done", 32'(done), 32'd0);
        op("mul3x5inj", MUL, 32'd3, 32'd5, 32'd15, 1'b0, 33, 5);
        tick();

        start = 1'b1; controle = MUL; op_a = 32'd7; op_b = 32'd6;
        tick();
        start = 1'b0;
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.stall", 32'(stall), 32'd0);
        chk("abort.result", result, 32'd15);
        cnt = 0;
        repeat (40) begin
            tick();
            if (done) cnt++;
        end
        chk("abort.nodone", 32'(cnt), 32'd0);
        start = 1'b1; abort = 1'b1;
        #1;
        chk("abort_start.stall", 32'(stall), 32'd0);
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start.busy", 32'(busy), 32'd0);

        op("div9/0b", DIV, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b1, 1, 0);
        tick();
        start = 1'b1; controle = MUL; op_a = 32'd7; op_b = 32'd6;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_rst.busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.result", result, 32'd0);
        chk("midrst.dbz", 32'(div_by_zero), 32'd0);
        chk("midrst.stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        tick();
        op("post_rst", MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
